// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM states, count width and wrap value for button_count_ctrl
package counter_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, RUN, RELEASE} state_t;
   localparam int COUNT_W = 5;
   localparam logic [COUNT_W-1:0] COUNT_MAX = 5'd31;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability-count debouncer with registered edge pulses
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_200mhz,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic rise,
   output logic fall
);
   localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   logic          sync_0, sync_1, primed;
   logic [1:0]    fill;
   logic [DW-1:0] stable_cnt;
   // primed blocks a rise until the button has been seen low after reset, so a held button never counts
   always_ff @(posedge clk_200mhz) begin
      if (rst) begin
         sync_0     <= 1'b0;
         sync_1     <= 1'b0;
         fill       <= 2'b00;
         primed     <= 1'b0;
         stable_cnt <= '0;
         btn_level  <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         sync_0 <= btn_in;
         sync_1 <= sync_0;
         fill   <= {fill[0], 1'b1};
         primed <= primed | (fill[1] & ~sync_1);
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_1 == btn_level) stable_cnt <= '0;
         else if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt <= '0;
            btn_level  <= sync_1;
            rise       <= sync_1 & primed;
            fall       <= ~sync_1;
         end else stable_cnt <= stable_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/button_count_ctrl.sv
// button_count_ctrl: debounced press-and-hold 5-bit tick counter with wrap pulse and LED toggle.
// Define BUTTON_COUNT_LONGPRESS_EN to clear the count and stop after LONG_CYCLES in RUN.
module button_count_ctrl
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_DIV        = 20,
   parameter int LONG_CYCLES     = 400000000
) (
   input  logic               clk_200mhz,
   input  logic               rst,
   input  logic               button,
   output logic [COUNT_W-1:0] count,
   output logic               wrap,
   output logic               pressed,
   output logic               led_0
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   state_t        state;
   logic [PW-1:0] presc;
   logic          tick, level, rise, fall, long_hit;
   assign tick = presc == PW'(TICK_DIV - 1);
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk_200mhz(clk_200mhz),
      .rst       (rst),
      .btn_in    (button),
      .btn_level (level),
      .rise      (rise),
      .fall      (fall)
   );
`ifdef BUTTON_COUNT_LONGPRESS_EN
   localparam int LW = LONG_CYCLES > 1 ? $clog2(LONG_CYCLES) : 1;
   logic [LW-1:0] run_cnt;
   assign long_hit = run_cnt == LW'(LONG_CYCLES - 1);
   always_ff @(posedge clk_200mhz) begin
      run_cnt <= (rst || state != RUN) ? '0 : run_cnt + 1'b1;
   end
`else
   assign long_hit = 1'b0;
`endif
   // a debounced release outranks a coincident tick, so the last partial tick never counts
   always_ff @(posedge clk_200mhz) begin
      if (rst) begin
         state   <= IDLE;
         presc   <= '0;
         count   <= '0;
         wrap    <= 1'b0;
         pressed <= 1'b0;
         led_0   <= 1'b0;
      end else begin
         presc   <= tick ? '0 : presc + 1'b1;
         pressed <= level;
         wrap    <= 1'b0;
         case (state)
            IDLE:  if (rise) state <= ARMED;
            ARMED: state <= fall ? RELEASE : tick ? RUN : ARMED;
            RUN: begin
               if (fall) state <= RELEASE;
               else if (long_hit) begin
                  count <= '0;
                  state <= RELEASE;
               end else if (tick) begin
                  count <= count + 1'b1;
                  wrap  <= count == COUNT_MAX;
                  led_0 <= led_0 ^ (count == COUNT_MAX);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_button_count_ctrl.sv
// tb_button_count_ctrl: directed scenarios plus random button activity, scoreboarded against a spec-level model
module tb_button_count_ctrl;
   localparam int D = 4, TD = 2, L = 100;
`ifdef BUTTON_COUNT_LONGPRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif
   logic clk_200mhz = 1'b0, rst = 1'b1, button = 1'b0;
   logic [4:0] count;
   logic wrap, pressed, led_0;
   int checks = 0, failures = 0, p_rises = 0, cyc = 0;
   logic [7:0] sbq[$];
   logic prev_pressed = 1'b0;
   int m_k, m_diff, m_cnt, m_run, m_tsr, m_ph;
   bit m_lvl, m_primed, m_rise, m_fall, m_led;
   bit m_recent[$];

   button_count_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD), .LONG_CYCLES(L)) dut (
      .clk_200mhz(clk_200mhz),
      .rst       (rst),
      .button    (button),
      .count     (count),
      .wrap      (wrap),
      .pressed   (pressed),
      .led_0     (led_0)
   );

   always #5 clk_200mhz = ~clk_200mhz;

   // expected {count, wrap, pressed, led_0} after the edge that samples b/r
   function automatic logic [7:0] model_edge(input bit b, input bit r);
      bit sync, tick, wr;
      int ph0;
      logic [7:0] e;
      if (r) begin
         m_k = 0; m_diff = 0; m_cnt = 0; m_run = 0; m_tsr = 0; m_ph = 0;
         m_lvl = 0; m_primed = 0; m_rise = 0; m_fall = 0; m_led = 0;
         m_recent.delete();
         return 8'h00;
      end
      m_k++;
      sync = (m_k >= 3) ? m_recent[0] : 1'b0;
      m_recent.push_back(b);
      if (m_recent.size() > 2) void'(m_recent.pop_front());
      tick = (m_k % TD) == 0;
      wr = 1'b0;
      ph0 = m_ph;
      if (tick) m_tsr++;
      case (m_ph)
         0: if (m_rise) begin m_ph = 1; m_tsr = 0; end
         1: m_ph = m_fall ? 3 : tick ? 2 : 1;
         2: begin
            if (m_fall) m_ph = 3;
            else if (LONG_EN && m_run == L - 1) begin m_cnt = 0; m_ph = 3; end
            else if (tick) begin
               m_cnt = (m_cnt + 1) % 32;
               if (m_cnt == 0) begin wr = 1'b1; m_led = !m_led; end
            end
         end
         default: m_ph = 0;
      endcase
      m_run = (ph0 == 2) ? m_run + 1 : 0;
      e = {5'(m_cnt), wr, m_lvl, m_led};
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (sync != m_lvl) begin
         m_diff++;
         if (m_diff == D) begin
            m_lvl = sync; m_diff = 0; m_rise = sync && m_primed; m_fall = !sync;
         end
      end else m_diff = 0;
      if (m_k >= 3 && !sync) m_primed = 1'b1;
      return e;
   endfunction

   task automatic step(input bit b, input bit r);
      @(negedge clk_200mhz);
      #1;
      button = b;
      rst = r;
      sbq.push_back(model_edge(b, r));
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic rst_seq();
      step(1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] e, a;
      forever begin
         @(negedge clk_200mhz);
         cyc++;
         if (pressed && !prev_pressed) p_rises++;
         prev_pressed = pressed;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {count, wrap, pressed, led_0};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL scoreboard cyc=%0d got cnt=%0d wrap=%0b pressed=%0b led=%0b want cnt=%0d wrap=%0b pressed=%0b led=%0b",
                        cyc, a[7:3], a[2], a[1], a[0], e[7:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      int r, n;
      bit lv;
      rst_seq();
      check("reset_count", count, 0);
      check("reset_wrap", wrap, 0);
      check("reset_pressed", pressed, 0);
      check("reset_led", led_0, 0);
      // short 3-cycle blip must not register
      repeat (3) step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      check("blip_pressed", pressed, 0);
      check("blip_count", count, 0);
      // long hold: first wrap, then count at the 70th tick
      rst_seq();
      for (int g = 0; g < 400 && wrap !== 1'b1; g++) step(1'b1, 1'b0);
      check("wrap_seen", wrap, 1);
      check("wrap_count", count, 0);
      check("wrap_led", led_0, 1);
      step(1'b1, 1'b0);
      check("wrap_one_cycle", wrap, 0);
      for (int g = 0; g < 400 && m_tsr < 70; g++) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("tick70_count", count, 5);
      repeat (20) step(1'b0, 1'b0);
      // release timed so the debounced fall lands on a tick at count 7
      rst_seq();
      for (int g = 0; g < 400 && count != 5'd4; g++) step(1'b1, 1'b0);
      check("reach4", count, 4);
      repeat (14) step(1'b0, 1'b0);
      check("release_tick_count", count, 7);
      check("release_pressed", pressed, 0);
      repeat (10) step(1'b0, 1'b0);
      check("release_idle_count", count, 7);
      // reset mid-RUN with the button held throughout
      rst_seq();
      for (int g = 0; g < 400 && count != 5'd12; g++) step(1'b1, 1'b0);
      check("reach12", count, 12);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      check("midrst_count", count, 0);
      check("midrst_led", led_0, 0);
      check("midrst_wrap", wrap, 0);
      repeat (40) step(1'b1, 1'b0);
      check("held_no_count", count, 0);
      repeat (20) step(1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0);
      check("repress_counts", int'(count != 5'd0), 1);
      repeat (20) step(1'b0, 1'b0);
      // bounce 1,0,1,1,0 then stable high
      rst_seq();
      p_rises = 0;
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
      repeat (40) step(1'b1, 1'b0);
      check("bounce_one_rise", p_rises, 1);
      check("bounce_counts", int'(count != 5'd0), 1);
      repeat (20) step(1'b0, 1'b0);
`ifdef BUTTON_COUNT_LONGPRESS_EN
      rst_seq();
      repeat (150) step(1'b1, 1'b0);
      check("long_cleared", count, 0);
      repeat (30) step(1'b1, 1'b0);
      check("long_stays", count, 0);
      repeat (20) step(1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0);
      check("long_repress", int'(count != 5'd0), 1);
      repeat (20) step(1'b0, 1'b0);
`endif
      for (int s = 0; s < 120; s++) begin
         r = $urandom_range(0, 19);
         if (r == 0) step(1'($urandom_range(0, 1)), 1'b1);
         else if (r < 5) begin
            n = $urandom_range(1, 3);
            repeat (n) step(1'($urandom_range(0, 1)), 1'b0);
         end else begin
            lv = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 60);
            repeat (n) step(lv, 1'b0);
         end
      end
      repeat (5) step(1'b0, 1'b0);
      @(negedge clk_200mhz);
      #2;
      check("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/button_count_ctrl.md
BUTTON_COUNT_CTRL -- requirements
Module: button_count_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples needed to accept a button level change.
REQ-002 SHALL have parameter TICK_DIV, default 20, clk_200mhz cycles per count tick (10 MHz equivalent).
REQ-003 SHALL have parameter LONG_CYCLES, default 400000000, held-time threshold for long press (used only under REQ-031).
REQ-004 SHALL have port clk_200mhz, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port button, input, 1, raw asynchronous push-button, active high.
REQ-007 SHALL have port count, output, 5, current count value.
REQ-008 SHALL have port wrap, output, 1, one-cycle pulse when count wraps 31->0.
REQ-009 SHALL have port pressed, output, 1, debounced button level.
REQ-010 SHALL have port led_0, output, 1, LED drive; toggles on each wrap.

Function
REQ-011 SHALL synchronize button through a 2-flop synchronizer before any other use.
REQ-012 SHALL update debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the stability count.
REQ-013 SHALL run a free-running tick prescaler 0..TICK_DIV-1 and assert an internal tick for one cycle when it reaches TICK_DIV-1.
REQ-014 SHALL implement FSM states IDLE, ARMED, RUN, RELEASE.
REQ-015 SHALL go IDLE->ARMED on debounced rising edge; ARMED->RUN on the next tick; RUN->RELEASE on debounced falling edge; RELEASE->IDLE on the next cycle.
REQ-016 SHALL increment count by 1 on each tick while in RUN only; count holds in all other states.
REQ-017 SHALL wrap count 31->0 modulo 2^5, asserting wrap in the same cycle count becomes 0.
REQ-018 SHALL toggle led_0 in the cycle wrap is asserted.
REQ-019 SHALL give priority to the debounced falling edge over a coincident tick: count does not increment in that cycle.
REQ-020 SHALL ensure first increment after press occurs on the second tick following the debounced rising edge (ARMED consumes one tick).
REQ-021 SHALL register all outputs; pressed lags the debounced level by at most one cycle.

Reset
REQ-022 SHALL on rst force count=0, wrap=0, pressed=0, led_0=0, FSM=IDLE, prescaler=0, debounce counter=0, synchronizer flops=0.
REQ-023 SHALL abort any operation when rst is asserted mid-RUN, with no wrap pulse generated in the reset cycle.
REQ-024 SHALL require a fresh debounced press after reset release, even if button is held throughout reset.

Configuration
REQ-031 SHALL, when macro BUTTON_COUNT_LONGPRESS_EN is defined, clear count to 0 without asserting wrap and go to RELEASE once RUN has lasted LONG_CYCLES cycles; the button must then be released and re-pressed to restart counting.
REQ-032 SHALL, without BUTTON_COUNT_LONGPRESS_EN, omit the long-press timer entirely, so RUN persists while held.

Structure
REQ-040 SHALL place the FSM state enum, count width constant (5) and the max count value (31) in shared package counter_pkg.
REQ-041 SHALL implement synchronizer plus debounce as sub-module btn_debounce (ports clk_200mhz, rst, btn_in, btn_level, rise, fall).
REQ-042 SHALL size prescaler and debounce counters with $clog2 of their parameters.

Verification (bench uses DEBOUNCE_CYCLES=4, TICK_DIV=2, LONG_CYCLES=100)
REQ-050 SHALL cover: button held high 3 cycles then low -> pressed stays 0, count stays 0.
REQ-051 SHALL cover: clean press held for 70 ticks -> count reaches 31, then 0 with one-cycle wrap, led_0=1, count=5 at the 70th tick.
REQ-052 SHALL cover: release coincident with a tick at count=7 -> count stays 7, FSM returns to IDLE.
REQ-053 SHALL cover: rst asserted with count=12 in RUN -> next cycle count=0, led_0=0, FSM IDLE, wrap=0; button held through reset -> no counting.
REQ-054 SHALL cover, with BUTTON_COUNT_LONGPRESS_EN: held >100 cycles -> count=0, no wrap, no further counting until release and re-press.
REQ-055 SHALL cover: bounce pattern 1,0,1,1,0 then stable 1 -> exactly one debounced rise, counting starts once.
